// File: rtl/fetch_phase_sequencer_pkg.sv
// Shared types and helpers for the byte-serial x86-64 fetch sequencer.
package fetch_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    OPCODE_1     = 3'd0,
    OPCODE_2     = 3'd1,
    MODRM        = 3'd2,
    SIB          = 3'd3,
    DISPLACEMENT = 3'd4,
    IMMEDIATE    = 3'd5,
    DONE         = 3'd6
  } fstate_e;

  typedef struct packed {
    logic [2:0] size;
    logic [1:0] cnt;
  } const_info_t;

  typedef struct packed {
    logic [3:0]  rex;
    logic [7:0]  opcode;
    logic        escape;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic [31:0] imm;
    logic [3:0]  len;
    logic        illegal;
  } fetch_rec_t;

  localparam logic [7:0] REX_LO    = 8'h40;
  localparam logic [7:0] REX_HI    = 8'h4F;
  localparam logic [7:0] ESCAPE_0F = 8'h0F;

  function automatic logic imm_size_ok(input logic [2:0] s);
    return (s == 3'd0) || (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
  endfunction

  // Byte k overwrites bits [31:8k] with its sign extension, so the value is
  // always the sign-extended little-endian constant seen so far.
  function automatic logic [31:0] merge_const(input logic [31:0] cur, input logic [1:0] k,
                                              input logic [7:0] b);
    logic [31:0] ext;
    logic [31:0] keep;
    ext  = {{24{b[7]}}, b} << {k, 3'b000};
    keep = (32'h1 << {k, 3'b000}) - 32'd1;
    return (cur & keep) | ext;
  endfunction

  function automatic fstate_e operand_next(input logic need_sib, input logic [2:0] disp_size,
                                           input logic [2:0] imm_size);
    fstate_e nxt;
    if (need_sib)                nxt = SIB;
    else if (disp_size != 3'd0)  nxt = DISPLACEMENT;
    else if (imm_size != 3'd0)   nxt = IMMEDIATE;
    else                         nxt = DONE;
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_phase_sequencer_modrm.sv
// ModRM/SIB addressing decode: whether a SIB byte follows and the displacement size.
module fetch_modrm_decode
  import fetch_phase_sequencer_pkg::*;
(
  input  logic [7:0] modrm,
  input  logic [7:0] sib,
  input  logic       use_sib,
  output logic       need_sib,
  output logic [2:0] disp_size
);

  logic [1:0] mode;
  logic [2:0] rm;
  logic [2:0] base;

  assign mode = modrm[7:6];
  assign rm   = modrm[2:0];
  assign base = sib[2:0];

  always_comb begin
    need_sib  = !use_sib && (mode != 2'b11) && (rm == 3'b100);
    disp_size = 3'd0;
    case (mode)
      2'b01:   disp_size = 3'd1;
      2'b10:   disp_size = 3'd4;
      // mod=00 with rm=101 is RIP-relative; with a SIB, base=101 means disp32 only.
      2'b00:   disp_size = ((use_sib ? base : rm) == 3'b101) ? 3'd4 : 3'd0;
      default: disp_size = 3'd0;
    endcase
  end

endmodule

// File: rtl/fetch_phase_sequencer.sv
// Byte-serial instruction fetch controller: walks the fetch phases one byte per
// cycle and presents the assembled instruction record over valid/ready.
module fetch_phase_sequencer
  import fetch_phase_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAX_LEN = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [7:0]        byte_data,
  input  logic [ADDR_W-1:0] byte_pc,
  output logic [7:0]        dec_opcode,
  output logic              dec_escape,
  input  logic              dec_has_modrm,
  input  logic [2:0]        dec_imm_size,
  input  logic              dec_illegal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_rex,
  output logic [7:0]        out_opcode,
  output logic              out_escape,
  output logic              out_has_modrm,
  output logic [7:0]        out_modrm,
  output logic              out_has_sib,
  output logic [7:0]        out_sib,
  output logic [31:0]       out_disp,
  output logic [31:0]       out_imm,
  output logic [3:0]        out_len,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_illegal,
  output logic [2:0]        phase
);

  fstate_e           state_q, state_d;
  fetch_rec_t        rec_q, rec_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  const_info_t       disp_q, disp_d, imm_q, imm_d;

  logic       accept;
  logic       md_use_sib;
  logic [7:0] md_modrm, md_sib;
  logic       md_need_sib;
  logic [2:0] md_disp_size;

  assign byte_ready = (state_q != DONE) && !flush;
  assign accept     = byte_valid && byte_ready;
  assign dec_escape = (state_q == OPCODE_2);
  assign dec_opcode = ((state_q == OPCODE_1) || (state_q == OPCODE_2)) ? byte_data : 8'h00;

  // One decoder serves both phases: ModRM comes live in MODRM, latched in SIB.
  assign md_use_sib = (state_q == SIB);
  assign md_modrm   = md_use_sib ? rec_q.modrm : byte_data;
  assign md_sib     = md_use_sib ? byte_data : 8'h00;

  fetch_modrm_decode u_modrm (
    .modrm     (md_modrm),
    .sib       (md_sib),
    .use_sib   (md_use_sib),
    .need_sib  (md_need_sib),
    .disp_size (md_disp_size)
  );

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    pc_d    = pc_q;
    disp_d  = disp_q;
    imm_d   = imm_q;
    if (flush || ((state_q == DONE) && out_ready)) begin
      state_d = OPCODE_1;
      rec_d   = '0;
      pc_d    = '0;
      disp_d  = '0;
      imm_d   = '0;
    end else if (accept) begin
      rec_d.len = rec_q.len + 4'd1;
      if (rec_q.len == 4'd0) pc_d = byte_pc;
      case (state_q)
        OPCODE_1, OPCODE_2: begin
          if ((state_q == OPCODE_1) && (byte_data >= REX_LO) && (byte_data <= REX_HI)) begin
            rec_d.rex = byte_data[3:0];
          end else if ((state_q == OPCODE_1) && (byte_data == ESCAPE_0F)) begin
            state_d = OPCODE_2;
          end else begin
            rec_d.opcode    = byte_data;
            rec_d.escape    = (state_q == OPCODE_2);
            rec_d.has_modrm = dec_has_modrm;
            imm_d.size      = dec_imm_size;
            if (dec_illegal || !imm_size_ok(dec_imm_size)) begin
              rec_d.illegal = 1'b1;
              state_d       = DONE;
            end else if (dec_has_modrm) begin
              state_d = MODRM;
            end else begin
              state_d = operand_next(1'b0, 3'd0, dec_imm_size);
            end
          end
        end
        MODRM: begin
          rec_d.modrm = byte_data;
          disp_d.size = md_disp_size;
          state_d     = operand_next(md_need_sib, md_disp_size, imm_q.size);
        end
        SIB: begin
          rec_d.has_sib = 1'b1;
          rec_d.sib     = byte_data;
          disp_d.size   = md_disp_size;
          state_d       = operand_next(1'b0, md_disp_size, imm_q.size);
        end
        DISPLACEMENT: begin
          rec_d.disp = merge_const(rec_q.disp, disp_q.cnt, byte_data);
          disp_d.cnt = disp_q.cnt + 2'd1;
          if (({1'b0, disp_q.cnt} + 3'd1) == disp_q.size)
            state_d = (imm_q.size != 3'd0) ? IMMEDIATE : DONE;
        end
        IMMEDIATE: begin
          rec_d.imm = merge_const(rec_q.imm, imm_q.cnt, byte_data);
          imm_d.cnt = imm_q.cnt + 2'd1;
          if (({1'b0, imm_q.cnt} + 3'd1) == imm_q.size) state_d = DONE;
        end
        default: ;
      endcase
      // Hitting the length limit mid-instruction stops consumption immediately.
      if ((state_d != DONE) && (rec_d.len == 4'(MAX_LEN))) begin
        state_d       = DONE;
        rec_d.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OPCODE_1;
      rec_q   <= '0;
      pc_q    <= '0;
      disp_q  <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      pc_q    <= pc_d;
      disp_q  <= disp_d;
      imm_q   <= imm_d;
    end
  end

  assign out_valid     = (state_q == DONE);
  assign out_rex       = rec_q.rex;
  assign out_opcode    = rec_q.opcode;
  assign out_escape    = rec_q.escape;
  assign out_has_modrm = rec_q.has_modrm;
  assign out_modrm     = rec_q.modrm;
  assign out_has_sib   = rec_q.has_sib;
  assign out_sib       = rec_q.sib;
  assign out_disp      = rec_q.disp;
  assign out_imm       = rec_q.imm;
  assign out_len       = rec_q.len;
  assign out_pc        = pc_q;
  assign out_illegal   = rec_q.illegal;
  assign phase         = state_q;

endmodule

// File: tb/tb_fetch_phase_sequencer.sv
// Self-checking bench: directed test-plan streams plus random byte streams,
// each record compared with an offset-based instruction parser.
module tb_fetch_phase_sequencer;

  localparam int          ADDR_W   = 32;
  localparam int          MAX_LEN  = 15;
  localparam int          STREAM_N = 1024;
  localparam logic [31:0] PC_BASE  = 32'h0040_0000;

  typedef struct packed {
    logic [3:0]  rex;
    logic [7:0]  opcode;
    logic        escape;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [31:0] disp;
    logic [31:0] imm;
    logic [3:0]  len;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic [7:0]        byte_data = 8'h00;
  logic [ADDR_W-1:0] byte_pc = '0;
  logic [7:0]        dec_opcode;
  logic              dec_escape;
  logic              dec_has_modrm;
  logic [2:0]        dec_imm_size;
  logic              dec_illegal;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        out_rex;
  logic [7:0]        out_opcode;
  logic              out_escape;
  logic              out_has_modrm;
  logic [7:0]        out_modrm;
  logic              out_has_sib;
  logic [7:0]        out_sib;
  logic [31:0]       out_disp;
  logic [31:0]       out_imm;
  logic [3:0]        out_len;
  logic [ADDR_W-1:0] out_pc;
  logic              out_illegal;
  logic [2:0]        phase;

  logic       tbl_modrm [0:511];
  logic [2:0] tbl_imm   [0:511];
  logic       tbl_ill   [0:511];
  logic [7:0] stream    [0:STREAM_N-1];
  int         stream_len;
  int         stream_lim;
  exp_t       obs_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_recs   = 0;

  always #5 clk = ~clk;

  assign dec_has_modrm = tbl_modrm[{dec_escape, dec_opcode}];
  assign dec_imm_size  = tbl_imm[{dec_escape, dec_opcode}];
  assign dec_illegal   = tbl_ill[{dec_escape, dec_opcode}];

  fetch_phase_sequencer #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data), .byte_pc(byte_pc),
    .dec_opcode(dec_opcode), .dec_escape(dec_escape), .dec_has_modrm(dec_has_modrm),
    .dec_imm_size(dec_imm_size), .dec_illegal(dec_illegal),
    .out_valid(out_valid), .out_ready(out_ready), .out_rex(out_rex), .out_opcode(out_opcode),
    .out_escape(out_escape), .out_has_modrm(out_has_modrm), .out_modrm(out_modrm),
    .out_has_sib(out_has_sib), .out_sib(out_sib), .out_disp(out_disp), .out_imm(out_imm),
    .out_len(out_len), .out_pc(out_pc), .out_illegal(out_illegal), .phase(phase)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic logic [7:0] sb(input int i);
    return (i >= 0 && i < stream_len) ? stream[i] : 8'h00;
  endfunction

  // Little-endian constant from the bytes below lim, sign-extended from the last one taken.
  function automatic logic [31:0] le_const(input int at, input int nbytes, input int lim);
    logic [31:0] v;
    int k;
    v = '0;
    k = 0;
    for (int j = 0; j < nbytes; j++) begin
      if (at + j < lim) begin
        v[8*j +: 8] = sb(at + j);
        k = j + 1;
      end
    end
    if (k > 0 && k < 4) for (int j = 8 * k; j < 32; j++) v[j] = v[8*k-1];
    return v;
  endfunction

  // Locate each field by byte offset, then truncate at the length limit.
  function automatic void model_parse(input int start, output exp_t e, output bit ok);
    int p, lim, opat, full, dsz, isz;
    logic [7:0] b, op, m, s;
    logic [1:0] md;
    logic [2:0] rm;
    bit esc, hm, nsib, bad;
    e    = '0;
    e.pc = PC_BASE + 32'(start);
    lim  = start + MAX_LEN;
    p    = start;
    b    = sb(p);
    while (p < lim && b >= 8'h40 && b <= 8'h4F) begin
      e.rex = b[3:0];
      p++;
      b = sb(p);
    end
    if (p >= lim) begin
      e.illegal = 1'b1;
      e.len     = 4'(MAX_LEN);
      ok        = (start + MAX_LEN <= stream_len);
      return;
    end
    esc = (b == 8'h0F);
    if (esc) p++;
    opat = p;
    op   = sb(p);
    p++;
    hm  = tbl_modrm[{esc, op}];
    isz = int'(tbl_imm[{esc, op}]);
    bad = tbl_ill[{esc, op}] || !(isz == 0 || isz == 1 || isz == 2 || isz == 4);
    if (opat < lim) begin
      e.opcode    = op;
      e.escape    = esc;
      e.has_modrm = hm;
    end
    if (!bad) begin
      if (hm) begin
        m = sb(p);
        if (p < lim) e.modrm = m;
        p++;
        md   = m[7:6];
        rm   = m[2:0];
        nsib = (md != 2'b11) && (rm == 3'b100);
        s    = 8'h00;
        if (nsib) begin
          s = sb(p);
          if (p < lim) begin
            e.has_sib = 1'b1;
            e.sib     = s;
          end
          p++;
        end
        if (md == 2'b01) dsz = 1;
        else if (md == 2'b10) dsz = 4;
        else if (md == 2'b00 && (nsib ? s[2:0] : rm) == 3'b101) dsz = 4;
        else dsz = 0;
        e.disp = le_const(p, dsz, lim);
        p += dsz;
      end
      e.imm = le_const(p, isz, lim);
      p += isz;
    end
    full      = p - start;
    e.illegal = bad || (full > MAX_LEN);
    e.len     = 4'((full > MAX_LEN) ? MAX_LEN : full);
    ok        = (start + int'(e.len) <= stream_len);
  endfunction

  function automatic int complete_limit();
    int s;
    exp_t e;
    bit ok;
    s = 0;
    while (s < stream_len) begin
      model_parse(s, e, ok);
      if (!ok) break;
      s += int'(e.len);
    end
    return s;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.rex = out_rex;         o.opcode = out_opcode;   o.escape = out_escape;
    o.has_modrm = out_has_modrm; o.modrm = out_modrm; o.has_sib = out_has_sib;
    o.sib = out_sib;         o.disp = out_disp;       o.imm = out_imm;
    o.len = out_len;         o.illegal = out_illegal; o.pc = out_pc;
    return o;
  endfunction

  task automatic compare_rec(input exp_t o, input exp_t e);
    check_val("rex", 32'(o.rex), 32'(e.rex));
    check_val("opcode", 32'(o.opcode), 32'(e.opcode));
    check_val("escape", 32'(o.escape), 32'(e.escape));
    check_val("has_modrm", 32'(o.has_modrm), 32'(e.has_modrm));
    check_val("modrm", 32'(o.modrm), 32'(e.modrm));
    check_val("has_sib", 32'(o.has_sib), 32'(e.has_sib));
    check_val("sib", 32'(o.sib), 32'(e.sib));
    check_val("disp", o.disp, e.disp);
    check_val("imm", o.imm, e.imm);
    check_val("len", 32'(o.len), 32'(e.len));
    check_val("illegal", 32'(o.illegal), 32'(e.illegal));
    check_val("pc", o.pc, e.pc);
  endtask

  // Stream stream[0:stream_lim) into the DUT; called and returns at a negedge.
  task automatic run_stream(input int valid_pct, input int ready_pct, input int stall);
    int   idx, exp_start, budget, vcnt;
    bit   pend, just_hs, okp;
    exp_t cur, o;
    idx = 0; exp_start = 0; budget = 20000; vcnt = 0; pend = 0; just_hs = 0;
    stream_lim = complete_limit();
    obs_q.delete();
    model_parse(0, cur, okp);
    while (exp_start < stream_lim && budget > 0) begin
      @(negedge clk);
      budget--;
      if (pend) begin
        check_val("latency", 32'(out_valid), 32'd1);
        pend = 0;
      end
      if (just_hs) begin
        check_val("ready_after_hs", 32'(byte_ready), 32'd1);
        just_hs = 0;
      end
      byte_valid = (idx < stream_lim) && ($urandom_range(99) < valid_pct);
      byte_data  = (idx < STREAM_N) ? stream[idx] : 8'h00;
      byte_pc    = PC_BASE + 32'(idx);
      out_ready  = (!out_valid || vcnt >= stall) && ($urandom_range(99) < ready_pct);
      if (out_valid) vcnt++;
      #1;
      if (byte_valid && byte_ready) begin
        idx++;
        if (idx == exp_start + int'(cur.len)) pend = 1;
      end
      if (out_valid && !out_ready) begin
        check_val("stall_ready", 32'(byte_ready), 32'd0);
        check_val("stall_len", 32'(out_len), 32'(cur.len));
      end
      if (out_valid && out_ready) begin
        o = observe();
        compare_rec(o, cur);
        obs_q.push_back(o);
        $display("rec %0d pc=%h len=%0d rex=%h esc=%b op=%h modrm=%h sib=%h disp=%h imm=%h ill=%b",
                 n_recs, o.pc, o.len, o.rex, o.escape, o.opcode, o.modrm, o.sib, o.disp, o.imm,
                 o.illegal);
        n_recs++;
        exp_start += int'(cur.len);
        if (exp_start < stream_lim) model_parse(exp_start, cur, okp);
        vcnt    = 0;
        just_hs = 1;
      end
    end
    if (budget == 0) check_val("stream_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [31:0] pc);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_pc    = pc;
    while (1) begin
      #1;
      if (byte_ready) break;
      @(negedge clk);
      t++;
      if (t > 50) begin
        check_val("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < 512; i++) begin
      tbl_modrm[i] = 1'b0;
      tbl_imm[i]   = 3'd0;
      tbl_ill[i]   = 1'b0;
    end
  endtask

  task automatic random_table();
    int r;
    for (int i = 0; i < 512; i++) begin
      r            = int'($urandom_range(15));
      tbl_modrm[i] = 1'($urandom_range(1));
      tbl_imm[i]   = (r < 5) ? 3'd0 : (r < 9) ? 3'd1 : (r < 12) ? 3'd2 : (r < 15) ? 3'd4 : 3'd3;
      tbl_ill[i]   = ($urandom_range(31) == 0);
    end
  endtask

  initial begin
    logic [7:0] dq [$];
    exp_t       o;

    clear_table();
    for (int i = 0; i < STREAM_N; i++) stream[i] = 8'h00;
    stream_len = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_ready", 32'(byte_ready), 32'd1);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_phase", 32'(phase), 32'd0);
    check_val("rst_len", 32'(out_len), 32'd0);
    check_val("rst_pc", out_pc, 32'd0);

    // Test-plan instructions back to back, each record held for 3 stalled cycles.
    tbl_modrm[9'h089] = 1'b1;
    tbl_modrm[9'h08B] = 1'b1;
    tbl_imm[9'h0B8]   = 3'd4;
    tbl_ill[9'h0D6]   = 1'b1;
    dq = {8'h48, 8'h89, 8'hE5,
          8'h8B, 8'h44, 8'h24, 8'hF8,
          8'h8B, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hB8, 8'h00, 8'h00, 8'h00, 8'h80,
          8'h0F, 8'h05,
          8'h8B, 8'h04, 8'h25, 8'h10, 8'h00, 8'h00, 8'h00};
    repeat (15) dq.push_back(8'h40);
    dq.push_back(8'hD6);
    dq.push_back(8'h90);
    stream_len = dq.size();
    for (int i = 0; i < stream_len; i++) stream[i] = dq[i];
    run_stream(100, 100, 3);
    check_val("dir_count", 32'(obs_q.size()), 32'd9);
    if (obs_q.size() >= 9) begin
      check_val("d0_rex", 32'(obs_q[0].rex), 32'h8);
      check_val("d0_modrm", 32'(obs_q[0].modrm), 32'hE5);
      check_val("d0_len", 32'(obs_q[0].len), 32'd3);
      check_val("d1_sib", 32'(obs_q[1].sib), 32'h24);
      check_val("d1_disp", obs_q[1].disp, 32'hFFFF_FFF8);
      check_val("d2_disp", obs_q[2].disp, 32'h1234_5678);
      check_val("d2_len", 32'(obs_q[2].len), 32'd6);
      check_val("d3_imm", obs_q[3].imm, 32'h8000_0000);
      check_val("d4_escape", 32'(obs_q[4].escape), 32'd1);
      check_val("d4_opcode", 32'(obs_q[4].opcode), 32'h05);
      check_val("d5_disp", obs_q[5].disp, 32'h0000_0010);
      check_val("d6_illegal", 32'(obs_q[6].illegal), 32'd1);
      check_val("d6_len", 32'(obs_q[6].len), 32'd15);
      check_val("d7_illegal", 32'(obs_q[7].illegal), 32'd1);
      check_val("d7_len", 32'(obs_q[7].len), 32'd1);
      check_val("d8_pc", obs_q[8].pc, PC_BASE + 32'd43);
    end

    // Flush partway through 8B 44 24 F8, then a lone NOP.
    send_byte(8'h8B, 32'h1000);
    send_byte(8'h44, 32'h1001);
    byte_valid = 1'b1;
    byte_data  = 8'h24;
    flush      = 1'b1;
    #1;
    check_val("flush_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    flush      = 1'b0;
    byte_valid = 1'b0;
    check_val("flush_phase", 32'(phase), 32'd0);
    check_val("flush_len", 32'(out_len), 32'd0);
    send_byte(8'h90, 32'h2000);
    o = observe();
    check_val("nop_valid", 32'(out_valid), 32'd1);
    check_val("nop_opcode", 32'(o.opcode), 32'h90);
    check_val("nop_len", 32'(o.len), 32'd1);
    check_val("nop_pc", o.pc, 32'h2000);
    // Flush together with out_ready in DONE drops the record.
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    check_val("done_flush_valid", 32'(out_valid), 32'd0);
    check_val("done_flush_opcode", 32'(out_opcode), 32'h00);

    // Reset in the middle of a displacement.
    send_byte(8'h8B, 32'h3000);
    send_byte(8'h05, 32'h3001);
    send_byte(8'h78, 32'h3002);
    check_val("pre_rst_phase", 32'(phase), 32'd4);
    rst        = 1'b1;
    flush      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h56;
    @(negedge clk);
    rst        = 1'b0;
    flush      = 1'b0;
    byte_valid = 1'b0;
    #1;
    check_val("mid_rst_phase", 32'(phase), 32'd0);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_opcode", 32'(out_opcode), 32'h00);
    check_val("mid_rst_modrm", 32'(out_modrm), 32'h00);
    check_val("mid_rst_disp", out_disp, 32'h0);
    check_val("mid_rst_len", 32'(out_len), 32'd0);
    check_val("mid_rst_pc", out_pc, 32'h0);
    check_val("mid_rst_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);

    // Random tables and byte streams with random gaps and back-pressure.
    for (int round = 0; round < 2; round++) begin
      random_table();
      stream_len = 500;
      for (int i = 0; i < STREAM_N; i++) begin
        if (i >= stream_len) stream[i] = 8'h00;
        else if ($urandom_range(9) == 0) stream[i] = 8'h0F;
        else stream[i] = 8'($urandom_range(255));
      end
      run_stream(70, 60, round);
      check_val("rand_done_phase", 32'(phase), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_phase_sequencer.md
Name: fetch_phase_sequencer

Overview:
- Byte-serial x86-64 instruction fetch controller. Consumes one instruction byte per cycle from the fetch buffer.
- Owns the fetch-phase state register (OPCODE_1, OPCODE_2, MODRM, SIB, DISPLACEMENT, IMMEDIATE, DONE) and the per-phase byte counter.
- Assembles REX, opcode, ModRM, SIB, displacement and immediate into one registered instruction record.
- Hands the record to the micro-instruction expander over a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of byte and instruction PCs.
- MAX_LEN, 15, architectural instruction length limit in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard any partial instruction; return to OPCODE_1 (branch redirect).
- byte_valid  in  1  byte_data/byte_pc valid.
- byte_ready  out  1  byte accepted when byte_valid&&byte_ready at posedge clk.
- byte_data  in  8  instruction byte.
- byte_pc  in  ADDR_W  address of byte_data.
- dec_opcode  out  8  opcode byte to the external combinational opcode table (byte_data in OPCODE_1/OPCODE_2).
- dec_escape  out  1  1 while in OPCODE_2 (0F map).
- dec_has_modrm  in  1  table result: opcode takes ModRM.
- dec_imm_size  in  3  table result: 0,1,2 or 4 bytes; other values are treated as illegal.
- dec_illegal  in  1  table result: undefined opcode.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts record.
- out_rex  out  4  REX.WRXB, 0 if no REX.
- out_opcode  out  8  final opcode byte.
- out_escape  out  1  opcode came from the 0F map.
- out_has_modrm  out  1  record carries ModRM.
- out_modrm  out  8  ModRM byte, 0 if absent.
- out_has_sib  out  1  record carries SIB.
- out_sib  out  8  SIB byte, 0 if absent.
- out_disp  out  32  sign-extended displacement, 0 if absent.
- out_imm  out  32  sign-extended immediate, 0 if absent.
- out_len  out  4  total byte count including REX.
- out_pc  out  ADDR_W  pc of the first byte (REX if present).
- out_illegal  out  1  illegal opcode or length overflow.
- phase  out  3  current state, for debug.

Behaviour:
- Reset:
  - state=OPCODE_1; out_valid=0; all record fields and counters 0; byte_ready=1 on the first cycle after reset.
  - rst wins over flush and all other events, including mid-DISPLACEMENT/IMMEDIATE.
- Byte acceptance:
  - byte_ready = (state != DONE).
  - At most one byte consumed per cycle.
  - len increments on every accepted byte.
  - out_pc is captured on the first accepted byte of each instruction.
- OPCODE_1:
  - Byte 0x40-0x4F: latch rex=byte[3:0] and stay in OPCODE_1. Repeated REX: the last one wins.
  - Byte 0x0F: go to OPCODE_2.
  - Any other byte: latch opcode, has_modrm, imm_size, illegal. Next state is MODRM if has_modrm; else IMMEDIATE if imm_size!=0; else DONE.
  - dec_illegal=1: go straight to DONE with out_illegal=1.
- OPCODE_2: same exits as the non-REX, non-0F case of OPCODE_1, with escape=1.
- MODRM:
  - Latch modrm.
  - sib needed iff mod!=11 && rm==100.
  - disp size: mod=01 gives 1; mod=10 gives 4; mod=00 && rm=101 gives 4 (RIP-relative); otherwise 0.
  - Next state: SIB if sib needed; else DISPLACEMENT if disp size!=0; else IMMEDIATE if imm_size!=0; else DONE.
- SIB:
  - Latch sib.
  - If mod=00 && base=101, disp size is 4.
  - Next state chosen by the same rule as MODRM.
- DISPLACEMENT / IMMEDIATE:
  - cnt starts at 0 on entry.
  - Byte k writes field[31:8k] with the byte sign-extended. The final value is therefore the sign-extended little-endian constant with no separate extension step.
  - When cnt+1==size, leave DISPLACEMENT for IMMEDIATE (imm_size!=0) or DONE. Leave IMMEDIATE for DONE.
- DONE:
  - out_valid=1 from the cycle after the last byte is accepted; latency from last byte to out_valid is 1.
  - All out_* fields are stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 next cycle, fields cleared, state=OPCODE_1.
  - Throughput is len+1 cycles per instruction.
- Length overflow:
  - If len reaches MAX_LEN before DONE, the next state is DONE with out_illegal=1.
  - Remaining bytes of that instruction are not consumed.
- flush:
  - Any state other than DONE: partial record discarded, state=OPCODE_1, len=0. A byte presented in that cycle is not accepted (byte_ready=0 during flush).
  - In DONE: the pending record is dropped and out_valid=0 next cycle.
- Simultaneous flush && out_ready in DONE: treated as flush.

Decomposition:
- Shared package holds:
  - fstate enum (OPCODE_1, OPCODE_2, MODRM, SIB, DISPLACEMENT, IMMEDIATE, DONE).
  - const_info_t {size, cnt}.
  - The fetched-instruction record struct.
  - REX_LO/REX_HI/ESCAPE_0F constants.
- Sub-module fetch_modrm_decode: combinational modrm/sib to {need_sib, disp_size}, shared by the MODRM and SIB states.

Test Plan:
- 48 89 E5, table has_modrm=1 imm=0: rex=8, opcode=89, modrm=E5, has_sib=0, disp=0, len=3, out_valid 1 cycle after E5.
- 8B 44 24 F8: sib=24, disp=FFFFFFF8, len=4. Then 8B 05 78 56 34 12: disp=12345678, len=6 (RIP-relative).
- B8 00 00 00 80 (imm_size=4) with out_ready low 3 cycles: imm=80000000, len=5. byte_ready=0 and fields stable while stalled; next instruction accepted right after the handshake.
- 0F 05: escape=1, opcode=05, len=2. 8B 04 25 10 00 00 00: sib=25, disp=00000010 (SIB base=101, mod=00).
- flush after 8B 44 of 8B 44 24 F8: no record emitted, then 90 gives opcode=90, len=1, out_pc=pc of 90. Repeat with rst asserted mid-DISPLACEMENT: all outputs 0, phase=OPCODE_1.
- 15 consecutive 0x40 bytes: out_illegal=1, len=15. Opcode with dec_illegal=1: out_illegal=1, len=1.
